// File: rtl/adder_share_arb_if.sv
// Bundle of request, adder and response signals for adder_share_arb.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding clients, the response consumer and the shared adder.
interface adder_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [DATA_W-1:0]         add_ina;
    logic [DATA_W-1:0]         add_inb;
    logic [DATA_W-1:0]         add_outx;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, add_outx, rsp_ready,
        output req_ready, add_ina, add_inb, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, add_outx, rsp_ready,
        input  req_ready, add_ina, add_inb, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one external combinational adder
// between NUM_REQ requesters. One operation at a time: IDLE grants and loads
// the adder inputs, EXEC lets the adder settle and captures the sum, RESP
// holds the tagged result until the consumer takes it.
// Optional statistics counters (op_count, wait_cycles) are built when the
// macro ADDER_SHARE_ARB_STATS_EN is defined.
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    adder_share_arb_if.slave bus
`ifdef ADDER_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      wait_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Pointer starts at the last requester so requester 0 is searched first.
    localparam logic [ID_W-1:0] RR_RESET  = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [DATA_W-1:0]   r_add_ina;
    logic [DATA_W-1:0]   r_add_inb;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_busy;

    logic [2*NUM_REQ-1:0] w_rot;
    logic [ID_W:0]        w_cand;
    logic [ID_W-1:0]      w_grant;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_ready;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;

    // Round-robin search: rotate valids so bit 0 is requester rr_ptr+1, take the first set bit.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        w_rot   = {bus.req_valid, bus.req_valid} >> ({1'b0, r_rr_ptr} + 1'b1);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && w_rot[0]) begin
                w_any  = 1'b1;
                w_cand = {1'b0, r_rr_ptr} + (ID_W + 1)'(k + 1);
                if (w_cand >= NUM_REQ_W) begin
                    w_cand = w_cand - NUM_REQ_W;
                end
                w_grant = w_cand[ID_W-1:0];
            end
            w_rot = w_rot >> 1;
        end
    end

    // Accept strobe and operand mux for the granted requester; only offered in IDLE out of reset.
    always_comb begin
        w_ready = '0;
        if (!RESET && r_state == IDLE && w_any) begin
            w_ready = NUM_REQ'(1) << w_grant;
        end
        w_sel_a = DATA_W'(bus.req_a >> (int'(w_grant) * DATA_W));
        w_sel_b = DATA_W'(bus.req_b >> (int'(w_grant) * DATA_W));
    end

    // Control FSM with registered adder inputs and response channel.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_rr_ptr    <= RR_RESET;
            r_add_ina   <= '0;
            r_add_inb   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_add_ina <= w_sel_a;
                        r_add_inb <= w_sel_b;
                        r_rsp_id  <= w_grant;
                        r_rr_ptr  <= w_grant;
                        r_busy    <= 1'b1;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= bus.add_outx;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.add_ina   = r_add_ina;
    assign bus.add_inb   = r_add_inb;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;

`ifdef ADDER_SHARE_ARB_STATS_EN
    logic [31:0] r_op_count;
    logic [31:0] r_wait_cycles;

    // Saturating counters of completed responses and of cycles where a request waits unserved.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op_count    <= '0;
            r_wait_cycles <= '0;
        end else begin
            if (r_rsp_valid && bus.rsp_ready && r_op_count != '1) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if ((|bus.req_valid) && !(|w_ready) && r_wait_cycles != '1) begin
                r_wait_cycles <= r_wait_cycles + 1'b1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign wait_cycles = r_wait_cycles;
`endif

endmodule
